// File: rtl/rr_arbiter8_pkg.sv
// rtl/rr_arbiter8_pkg.sv - shared types, sizes and one-hot encoder for the 8-way arbiter
package arb8_pkg;

   localparam int NUM_REQ = 8;
   localparam int IDX_W   = 3;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   // OR-reduction encoder; exact for one-hot input, returns 0 for all-zero input.
   function automatic logic [IDX_W-1:0] onehot8_to_idx(input logic [NUM_REQ-1:0] oh);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (oh[i]) begin
            idx = idx | IDX_W'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// rtl/rr_arbiter8_if.sv - request/grant bundle between requesters (master) and arbiter (slave)
interface rr_arbiter8_if;
   import arb8_pkg::*;

   logic [NUM_REQ-1:0] req_i;
   logic               release_i;
   logic [NUM_REQ-1:0] grant_o;
   logic [IDX_W-1:0]   grant_idx_o;
   logic               grant_valid_o;
   logic               timeout_o;

   modport master (
      output req_i,
      output release_i,
      input  grant_o,
      input  grant_idx_o,
      input  grant_valid_o,
      input  timeout_o
   );

   modport slave (
      input  req_i,
      input  release_i,
      output grant_o,
      output grant_idx_o,
      output grant_valid_o,
      output timeout_o
   );

endinterface

// File: rtl/rr_arbiter8_pick.sv
// rtl/rr_arbiter8_pick.sv - combinational rotate-priority picker; ptr_i names the top-priority requester
module rr_pick8
   import arb8_pkg::*;
(
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] win_onehot_o,
   output logic [IDX_W-1:0]   win_idx_o
);

   logic [2*NUM_REQ-1:0] req_dbl;
   logic [2*NUM_REQ-1:0] req_shr;
   logic [NUM_REQ-1:0]   req_rot;
   logic [NUM_REQ-1:0]   win_rot;
   logic [2*NUM_REQ-1:0] win_dbl;

   // Rotate so bit 0 is requester ptr, isolate lowest set bit, rotate back.
   always_comb begin
      req_dbl      = {req_i, req_i};
      req_shr      = req_dbl >> ptr_i;
      req_rot      = req_shr[NUM_REQ-1:0];
      win_rot      = req_rot & (~req_rot + {{(NUM_REQ-1){1'b0}}, 1'b1});
      win_dbl      = {win_rot, win_rot} << ptr_i;
      win_onehot_o = win_dbl[2*NUM_REQ-1:NUM_REQ];
      win_idx_o    = onehot8_to_idx(win_onehot_o);
   end

endmodule

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - round-robin arbiter for 8 requesters with registered one-hot grant and index
// Define ARB8_TIMEOUT_EN to build the watchdog that revokes a grant after TIMEOUT_CYCLES busy cycles.
module rr_arbiter8
   import arb8_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
)
(
   input  logic         clk,
   input  logic         rst_n,
   rr_arbiter8_if.slave bus
);

   arb_state_e         state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic               timeout_q, timeout_d;

   logic [NUM_REQ-1:0] win_onehot;
   logic [IDX_W-1:0]   win_idx;
   logic               expire;

   rr_pick8 u_pick (
      .req_i        (bus.req_i),
      .ptr_i        (ptr_q),
      .win_onehot_o (win_onehot),
      .win_idx_o    (win_idx)
   );

`ifdef ARB8_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counter is zero throughout IDLE, so the first BUSY cycle always sees 0.
   always_comb begin
      cnt_d = '0;
      if (state_q == ARB_BUSY) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A simultaneous release wins, so the revoke is not flagged as a timeout.
   assign expire = (state_q == ARB_BUSY) && !bus.release_i &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   // Watchdog not built: a grant is held until released.
   assign expire = 1'b0 && (TIMEOUT_CYCLES >= 1);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ARB_IDLE;
         grant_q   <= '0;
         idx_q     <= '0;
         ptr_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         idx_q     <= idx_d;
         ptr_q     <= ptr_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE: begin
            if (|bus.req_i) begin
               state_d = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            if (bus.release_i || expire) begin
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // Index holds through IDLE; only the grant vector and pointer move on release.
   always_comb begin
      grant_d   = grant_q;
      idx_d     = idx_q;
      ptr_d     = ptr_q;
      timeout_d = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (|bus.req_i) begin
               grant_d = win_onehot;
               idx_d   = win_idx;
            end
         end
         ARB_BUSY: begin
            if (bus.release_i || expire) begin
               grant_d   = '0;
               ptr_d     = idx_q + 3'd1;
               timeout_d = expire;
            end
         end
         default: begin
            grant_d = '0;
         end
      endcase
   end

   assign bus.grant_o       = grant_q;
   assign bus.grant_idx_o   = idx_q;
   assign bus.grant_valid_o = (state_q == ARB_BUSY);
   assign bus.timeout_o     = timeout_q;

endmodule
